// File: rtl/exe_stage_md.sv
// Execute stage: one-hot ALU, multi-cycle multiply, iterative restoring divide,
// data SRAM request generation and a result bypass toward decode.
module exe_stage_md #(
  parameter int MUL_LAT  = 2,
  parameter int DIV_BITS = 1,
  parameter int FWD_EN   = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ds2es_valid,
  output logic        es_allowin,
  input  logic [31:0] ds_pc,
  input  logic [31:0] ds_src1,
  input  logic [31:0] ds_src2,
  input  logic [31:0] ds_rkd,
  input  logic [11:0] ds_alu_op,
  input  logic [2:0]  ds_md_op,
  input  logic        ds_mem_we,
  input  logic        ds_res_from_mem,
  input  logic        ds_gr_we,
  input  logic [1:0]  ds_mem_size,
  input  logic [4:0]  ds_dest,
  input  logic        flush,
  input  logic        ms_allowin,
  output logic        es2ms_valid,
  output logic [31:0] es_pc,
  output logic [31:0] es_result,
  output logic        es_res_from_mem,
  output logic        es_gr_we,
  output logic [4:0]  es_dest,
  output logic        data_sram_en,
  output logic [3:0]  data_sram_we,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata,
  output logic        fwd_valid,
  output logic [4:0]  fwd_dest,
  output logic [31:0] fwd_data,
  output logic        fwd_stall
);
  localparam int DIV_ITERS = 32 / DIV_BITS;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t      state_q;
  logic        es_valid_q;
  logic [4:0]  cnt_q;
  logic [31:0] pc_q, src1_q, src2_q, rkd_q;
  logic [11:0] alu_op_q;
  logic [2:0]  md_op_q;
  logic        mem_we_q, res_from_mem_q, gr_we_q;
  logic [1:0]  mem_size_q;
  logic [4:0]  dest_q;
  logic [31:0] quo_q, rem_q, dsr_q;
  logic [31:0] quo_d, rem_d;

  logic        es_ready_go, accept, ds_div_signed;
  logic [31:0] ds_a_abs, ds_b_abs;
  logic [31:0] alu_res, md_res, div_q, div_r;
  logic        div_sgn, q_neg, r_neg, div_zero, mul_sx, fwd_v;
  logic signed [32:0] mul_a, mul_b;
  logic signed [63:0] mul_p;
  logic [3:0]  byte_mask;

  function automatic logic [31:0] alu_f(input logic [11:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [31:0] r;
    r = '0;
    if (op[0])  r = r | (a + b);
    if (op[1])  r = r | (a - b);
    if (op[2])  r = r | {31'd0, $signed(a) < $signed(b)};
    if (op[3])  r = r | {31'd0, a < b};
    if (op[4])  r = r | (a & b);
    if (op[5])  r = r | ~(a | b);
    if (op[6])  r = r | (a | b);
    if (op[7])  r = r | (a ^ b);
    if (op[8])  r = r | (a << b[4:0]);
    if (op[9])  r = r | (a >> b[4:0]);
    if (op[10]) r = r | $unsigned($signed(a) >>> b[4:0]);
    if (op[11]) r = r | b;
    return r;
  endfunction

  // One restoring step: shift the next dividend bit into the partial remainder.
  function automatic logic [63:0] div_step(input logic [31:0] r, input logic [31:0] q,
                                           input logic [31:0] d);
    logic [32:0] t;
    logic [31:0] qn;
    t  = {r, q[31]};
    qn = {q[30:0], 1'b0};
    if (t >= {1'b0, d}) begin
      t     = t - {1'b0, d};
      qn[0] = 1'b1;
    end
    return {t[31:0], qn};
  endfunction

  assign es_ready_go = (state_q == S_IDLE) || (state_q == S_DONE);
  // A flushed instruction is dead, so its slot can take a new one in the same cycle.
  assign es_allowin  = resetn && (!es_valid_q || (es_ready_go && ms_allowin) || flush);
  assign accept      = ds2es_valid && es_allowin;
  assign es2ms_valid = es_valid_q && es_ready_go && !flush;

  assign ds_div_signed = ~ds_md_op[0];
  assign ds_a_abs = (ds_div_signed && ds_src1[31]) ? -ds_src1 : ds_src1;
  assign ds_b_abs = (ds_div_signed && ds_src2[31]) ? -ds_src2 : ds_src2;

  always_comb begin
    rem_d = rem_q;
    quo_d = quo_q;
    for (int i = 0; i < DIV_BITS; i++) {rem_d, quo_d} = div_step(rem_d, quo_d, dsr_q);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      es_valid_q <= 1'b0;
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
      dsr_q      <= '0;
    end else begin
      if (es_allowin) es_valid_q <= ds2es_valid;
      if (accept) begin
        quo_q <= ds_a_abs;
        rem_q <= '0;
        dsr_q <= ds_b_abs;
        case (ds_md_op)
          3'd0:             begin state_q <= S_IDLE; cnt_q <= '0; end
          3'd1, 3'd2, 3'd3: begin state_q <= S_MUL;  cnt_q <= 5'(MUL_LAT - 1); end
          default:          begin state_q <= S_DIV;  cnt_q <= 5'(DIV_ITERS - 1); end
        endcase
      end else if (flush) begin
        state_q <= S_IDLE;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          S_MUL: if (cnt_q == 5'd0) state_q <= S_DONE; else cnt_q <= cnt_q - 5'd1;
          S_DIV: begin
            quo_q <= quo_d;
            rem_q <= rem_d;
            if (cnt_q == 5'd0) state_q <= S_DONE; else cnt_q <= cnt_q - 5'd1;
          end
          S_DONE: if (es_allowin) state_q <= S_IDLE;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc_q           <= '0;
      src1_q         <= '0;
      src2_q         <= '0;
      rkd_q          <= '0;
      alu_op_q       <= '0;
      md_op_q        <= '0;
      mem_we_q       <= 1'b0;
      res_from_mem_q <= 1'b0;
      gr_we_q        <= 1'b0;
      mem_size_q     <= '0;
      dest_q         <= '0;
    end else if (accept) begin
      pc_q           <= ds_pc;
      src1_q         <= ds_src1;
      src2_q         <= ds_src2;
      rkd_q          <= ds_rkd;
      alu_op_q       <= ds_alu_op;
      md_op_q        <= ds_md_op;
      mem_we_q       <= ds_mem_we;
      res_from_mem_q <= ds_res_from_mem;
      gr_we_q        <= ds_gr_we;
      mem_size_q     <= ds_mem_size;
      dest_q         <= ds_dest;
    end
  end

  assign alu_res = alu_f(alu_op_q, src1_q, src2_q);

  // Sign-extend for mulh only; the truncated 64-bit product is exact for both signednesses.
  assign mul_sx = (md_op_q == 3'd2);
  assign mul_a  = {mul_sx & src1_q[31], src1_q};
  assign mul_b  = {mul_sx & src2_q[31], src2_q};
  assign mul_p  = 64'(mul_a) * 64'(mul_b);

  assign div_sgn  = ~md_op_q[0];
  assign q_neg    = div_sgn & (src1_q[31] ^ src2_q[31]);
  assign r_neg    = div_sgn & src1_q[31];
  assign div_zero = (src2_q == 32'd0);
  assign div_q    = div_zero ? 32'hFFFF_FFFF : (q_neg ? -quo_q : quo_q);
  assign div_r    = div_zero ? src1_q : (r_neg ? -rem_q : rem_q);

  always_comb begin
    md_res = '0;
    case (md_op_q)
      3'd1:       md_res = mul_p[31:0];
      3'd2, 3'd3: md_res = mul_p[63:32];
      3'd4, 3'd5: md_res = div_q;
      3'd6, 3'd7: md_res = div_r;
      default:    md_res = '0;
    endcase
  end

  assign es_result       = (md_op_q != 3'd0) ? md_res : alu_res;
  assign es_pc           = pc_q;
  assign es_res_from_mem = res_from_mem_q;
  assign es_gr_we        = gr_we_q;
  assign es_dest         = dest_q;

  assign data_sram_en   = es_valid_q && (mem_we_q || res_from_mem_q) && ms_allowin && !flush;
  assign data_sram_addr = alu_res;

  always_comb begin
    byte_mask = 4'b1111;
    case (mem_size_q)
      2'd0:    byte_mask = 4'b0001 << alu_res[1:0];
      2'd1:    byte_mask = alu_res[1] ? 4'b1100 : 4'b0011;
      default: byte_mask = 4'b1111;
    endcase
  end

  assign data_sram_we    = (data_sram_en && mem_we_q) ? byte_mask : 4'b0000;
  assign data_sram_wdata = (mem_size_q == 2'd0) ? {4{rkd_q[7:0]}} :
                           (mem_size_q == 2'd1) ? {2{rkd_q[15:0]}} : rkd_q;

  assign fwd_v     = es_valid_q && gr_we_q && (dest_q != 5'd0);
  assign fwd_valid = (FWD_EN != 0) && fwd_v;
  assign fwd_dest  = (FWD_EN != 0) ? dest_q : 5'd0;
  assign fwd_data  = (FWD_EN != 0) ? es_result : 32'd0;
  assign fwd_stall = fwd_valid && (res_from_mem_q || !es_ready_go);
endmodule

// File: tb/tb_exe_stage_md.sv
// Directed bench for exe_stage_md: handshake, multiply, divide corner cases, stores,
// forwarding, flush and asynchronous reset.
module tb_exe_stage_md;
  localparam int MUL_LAT  = 2;
  localparam int DIV_BITS = 1;
  localparam int DIV_CYC  = 32 / DIV_BITS + 1;
  localparam logic [11:0] ALU_ADD = 12'h001;

  logic        clk, resetn, ds2es_valid, es_allowin;
  logic [31:0] ds_pc, ds_src1, ds_src2, ds_rkd;
  logic [11:0] ds_alu_op;
  logic [2:0]  ds_md_op;
  logic        ds_mem_we, ds_res_from_mem, ds_gr_we;
  logic [1:0]  ds_mem_size;
  logic [4:0]  ds_dest;
  logic        flush, ms_allowin, es2ms_valid;
  logic [31:0] es_pc, es_result;
  logic        es_res_from_mem, es_gr_we;
  logic [4:0]  es_dest;
  logic        data_sram_en;
  logic [3:0]  data_sram_we;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic        fwd_valid;
  logic [4:0]  fwd_dest;
  logic [31:0] fwd_data;
  logic        fwd_stall;

  int checks = 0;
  int errors = 0;

  exe_stage_md #(.MUL_LAT(MUL_LAT), .DIV_BITS(DIV_BITS), .FWD_EN(1)) dut (
    .clk(clk), .resetn(resetn), .ds2es_valid(ds2es_valid), .es_allowin(es_allowin),
    .ds_pc(ds_pc), .ds_src1(ds_src1), .ds_src2(ds_src2), .ds_rkd(ds_rkd),
    .ds_alu_op(ds_alu_op), .ds_md_op(ds_md_op), .ds_mem_we(ds_mem_we),
    .ds_res_from_mem(ds_res_from_mem), .ds_gr_we(ds_gr_we), .ds_mem_size(ds_mem_size),
    .ds_dest(ds_dest), .flush(flush), .ms_allowin(ms_allowin), .es2ms_valid(es2ms_valid),
    .es_pc(es_pc), .es_result(es_result), .es_res_from_mem(es_res_from_mem),
    .es_gr_we(es_gr_we), .es_dest(es_dest), .data_sram_en(data_sram_en),
    .data_sram_we(data_sram_we), .data_sram_addr(data_sram_addr),
    .data_sram_wdata(data_sram_wdata), .fwd_valid(fwd_valid), .fwd_dest(fwd_dest),
    .fwd_data(fwd_data), .fwd_stall(fwd_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] rkd, input logic [11:0] aop, input logic [2:0] mop,
                       input logic we, input logic rfm, input logic gw,
                       input logic [1:0] sz, input logic [4:0] dst);
    ds2es_valid = 1'b1; ds_pc = pc; ds_src1 = a; ds_src2 = b; ds_rkd = rkd;
    ds_alu_op = aop; ds_md_op = mop; ds_mem_we = we; ds_res_from_mem = rfm;
    ds_gr_we = gw; ds_mem_size = sz; ds_dest = dst;
  endtask

  // Issues one instruction and waits (bounded) for it to be offered downstream.
  task automatic run_op(input logic [11:0] aop, input logic [2:0] mop, input logic [31:0] a,
                        input logic [31:0] b, output logic [31:0] res, output int cyc,
                        output int low, output int stl, output bit tout);
    @(negedge clk);
    drive(32'h1c00_0200, a, b, 32'd0, aop, mop, 1'b0, 1'b0, 1'b1, 2'd2, 5'd6);
    @(posedge clk);
    @(negedge clk);
    ds2es_valid = 1'b0;
    #1;
    cyc = 1; low = 0; stl = 0;
    while (!es2ms_valid && cyc < 100) begin
      if (!es_allowin) low++;
      if (fwd_stall) stl++;
      @(negedge clk); #1;
      cyc++;
    end
    res  = es_result;
    tout = !es2ms_valid;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    checks++; if (es2ms_valid !== 1'b0) begin errors++; $display("FAIL rst_es2ms_valid: got %b want 0", es2ms_valid); end
    checks++; if (es_allowin !== 1'b0) begin errors++; $display("FAIL rst_allowin: got %b want 0", es_allowin); end
    checks++; if (data_sram_en !== 1'b0) begin errors++; $display("FAIL rst_sram_en: got %b want 0", data_sram_en); end
    checks++; if (fwd_valid !== 1'b0) begin errors++; $display("FAIL rst_fwd_valid: got %b want 0", fwd_valid); end
    checks++; if (es_result !== 32'd0) begin errors++; $display("FAIL rst_result: got %h want 0", es_result); end
    @(negedge clk);
    resetn = 1'b1;
    #1;
    checks++; if (es_allowin !== 1'b1) begin errors++; $display("FAIL post_rst_allowin: got %b want 1", es_allowin); end
  endtask

  task automatic test_add();
    @(negedge clk);
    drive(32'h1c00_0100, 32'd3, 32'd4, 32'd0, ALU_ADD, 3'd0, 1'b0, 1'b0, 1'b1, 2'd2, 5'd5);
    #1;
    checks++; if (es_allowin !== 1'b1) begin errors++; $display("FAIL add_allowin: got %b want 1", es_allowin); end
    @(negedge clk);
    ds2es_valid = 1'b0;
    #1;
    checks++; if (es2ms_valid !== 1'b1) begin errors++; $display("FAIL add_valid: got %b want 1", es2ms_valid); end
    checks++; if (es_result !== 32'd7) begin errors++; $display("FAIL add_result: got %h want %h", es_result, 32'd7); end
    checks++; if (es_pc !== 32'h1c00_0100) begin errors++; $display("FAIL add_pc: got %h want 1c000100", es_pc); end
    checks++; if (fwd_data !== 32'd7 || fwd_dest !== 5'd5) begin errors++; $display("FAIL add_fwd: got %h/%0d want 7/5", fwd_data, fwd_dest); end
    checks++; if (fwd_stall !== 1'b0) begin errors++; $display("FAIL add_stall: got %b want 0", fwd_stall); end
    @(negedge clk); #1;
    checks++; if (es2ms_valid !== 1'b0) begin errors++; $display("FAIL add_drain: got %b want 0", es2ms_valid); end
  endtask

  task automatic test_mul();
    logic [31:0] r; int c, l, s; bit t;
    run_op(12'd0, 3'd2, 32'h8000_0000, 32'd2, r, c, l, s, t);
    checks++; if (t || r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mulh_result: got %h want ffffffff", r); end
    checks++; if (l != MUL_LAT) begin errors++; $display("FAIL mulh_allowin_low: got %0d want %0d", l, MUL_LAT); end
    checks++; if (s != MUL_LAT) begin errors++; $display("FAIL mulh_fwd_stall: got %0d want %0d", s, MUL_LAT); end
    checks++; if (fwd_stall !== 1'b0) begin errors++; $display("FAIL mulh_done_stall: got %b want 0", fwd_stall); end
    run_op(12'd0, 3'd1, 32'hFFFF_FFFD, 32'd5, r, c, l, s, t);
    checks++; if (t || r !== 32'hFFFF_FFF1) begin errors++; $display("FAIL mul_low: got %h want fffffff1", r); end
    run_op(12'd0, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, c, l, s, t);
    checks++; if (t || r !== 32'hFFFF_FFFE) begin errors++; $display("FAIL mulhu: got %h want fffffffe", r); end
    checks++; if (c != MUL_LAT + 1) begin errors++; $display("FAIL mulhu_cycles: got %0d want %0d", c, MUL_LAT + 1); end
  endtask

  task automatic test_div();
    logic [2:0]  op_t [10];
    logic [31:0] a_t [10];
    logic [31:0] b_t [10];
    logic [31:0] e_t [10];
    logic [31:0] r; int c, l, s; bit t;
    op_t = '{3'd4, 3'd6, 3'd5, 3'd4, 3'd7, 3'd6, 3'd7, 3'd6, 3'd5, 3'd6};
    a_t  = '{32'd7, 32'd7, 32'h1234, 32'h8000_0000, 32'd100, 32'hFFFF_FFF9, 32'hDEAD,
             32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'h8000_0000};
    b_t  = '{32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'd0, 32'hFFFF_FFFF, 32'd7, 32'd2, 32'd0,
             32'd0, 32'd3, 32'hFFFF_FFFF};
    e_t  = '{32'hFFFF_FFFD, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'd2, 32'hFFFF_FFFF,
             32'hDEAD, 32'hFFFF_FFF9, 32'h5555_5555, 32'd0};
    for (int i = 0; i < 10; i++) begin
      run_op(12'd0, op_t[i], a_t[i], b_t[i], r, c, l, s, t);
      checks++; if (t || r !== e_t[i]) begin errors++; $display("FAIL div_vec%0d: got %h want %h", i, r, e_t[i]); end
      checks++; if (c != DIV_CYC) begin errors++; $display("FAIL div_cycles%0d: got %0d want %0d", i, c, DIV_CYC); end
    end
  endtask

  task automatic test_back_to_back();
    int c;
    @(negedge clk);
    drive(32'h1c00_0300, 32'h0001_2345, 32'h10, 32'd0, 12'd0, 3'd1, 1'b0, 1'b0, 1'b1, 2'd2, 5'd8);
    @(posedge clk);
    @(negedge clk);
    ds2es_valid = 1'b0;
    #1;
    c = 1;
    while (!es2ms_valid && c < 10) begin @(negedge clk); #1; c++; end
    checks++; if (!es2ms_valid || es_result !== 32'h0012_3450) begin errors++; $display("FAIL b2b_first: got %h want 00123450", es_result); end
    drive(32'h1c00_0304, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 12'd0, 3'd3, 1'b0, 1'b0, 1'b1, 2'd2, 5'd9);
    #1;
    checks++; if (es_allowin !== 1'b1) begin errors++; $display("FAIL b2b_allowin_done: got %b want 1", es_allowin); end
    @(negedge clk);
    ds2es_valid = 1'b0;
    #1;
    checks++; if (es_allowin !== 1'b0) begin errors++; $display("FAIL b2b_second_busy: got %b want 0", es_allowin); end
    c = 1;
    while (!es2ms_valid && c < 10) begin @(negedge clk); #1; c++; end
    checks++; if (c != MUL_LAT + 1 || es_result !== 32'hFFFF_FFFE) begin errors++; $display("FAIL b2b_second: got %h in %0d want fffffffe in %0d", es_result, c, MUL_LAT + 1); end
  endtask

  task automatic test_store();
    int en_cnt;
    ms_allowin = 1'b1;
    @(negedge clk);
    drive(32'h1c00_0400, 32'h1000, 32'd3, 32'h0000_00AB, ALU_ADD, 3'd0, 1'b1, 1'b0, 1'b0, 2'd0, 5'd0);
    @(negedge clk);
    drive(32'h1c00_0404, 32'h1000, 32'd2, 32'h0000_1234, ALU_ADD, 3'd0, 1'b1, 1'b0, 1'b0, 2'd1, 5'd0);
    #1;
    checks++; if (data_sram_en !== 1'b1 || data_sram_we !== 4'b1000) begin errors++; $display("FAIL stb_en_we: got %b/%b want 1/1000", data_sram_en, data_sram_we); end
    checks++; if (data_sram_wdata !== 32'hABAB_ABAB) begin errors++; $display("FAIL stb_wdata: got %h want ababab ab", data_sram_wdata); end
    checks++; if (data_sram_addr !== 32'h1003) begin errors++; $display("FAIL stb_addr: got %h want 00001003", data_sram_addr); end
    @(negedge clk);
    ds2es_valid = 1'b0;
    ms_allowin = 1'b0;
    en_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (data_sram_en) en_cnt++;
      @(negedge clk);
    end
    checks++; if (en_cnt != 0) begin errors++; $display("FAIL sth_stalled_en: got %0d want 0", en_cnt); end
    ms_allowin = 1'b1;
    #1;
    checks++; if (data_sram_en !== 1'b1 || data_sram_we !== 4'b1100) begin errors++; $display("FAIL sth_en_we: got %b/%b want 1/1100", data_sram_en, data_sram_we); end
    checks++; if (data_sram_wdata !== 32'h1234_1234) begin errors++; $display("FAIL sth_wdata: got %h want 12341234", data_sram_wdata); end
    @(negedge clk); #1;
    checks++; if (data_sram_en !== 1'b0) begin errors++; $display("FAIL sth_once: got %b want 0", data_sram_en); end
    drive(32'h1c00_0408, 32'h2000, 32'd0, 32'hDEAD_BEEF, ALU_ADD, 3'd0, 1'b1, 1'b0, 1'b0, 2'd2, 5'd0);
    @(negedge clk);
    ds2es_valid = 1'b0;
    #1;
    checks++; if (data_sram_we !== 4'b1111 || data_sram_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL stw: got %b/%h want 1111/deadbeef", data_sram_we, data_sram_wdata); end
  endtask

  task automatic test_forward();
    @(negedge clk);
    drive(32'h1c00_0500, 32'h3000, 32'd4, 32'd0, ALU_ADD, 3'd0, 1'b0, 1'b1, 1'b1, 2'd2, 5'd9);
    @(negedge clk);
    drive(32'h1c00_0504, 32'd1, 32'd1, 32'd0, ALU_ADD, 3'd0, 1'b0, 1'b0, 1'b1, 2'd2, 5'd0);
    #1;
    checks++; if (fwd_valid !== 1'b1 || fwd_stall !== 1'b1 || fwd_dest !== 5'd9) begin errors++; $display("FAIL ld_fwd: got %b/%b/%0d want 1/1/9", fwd_valid, fwd_stall, fwd_dest); end
    checks++; if (data_sram_en !== 1'b1 || data_sram_we !== 4'b0000 || data_sram_addr !== 32'h3004) begin errors++; $display("FAIL ld_req: got %b/%b/%h want 1/0000/00003004", data_sram_en, data_sram_we, data_sram_addr); end
    @(negedge clk);
    ds2es_valid = 1'b0;
    #1;
    checks++; if (fwd_valid !== 1'b0 || es2ms_valid !== 1'b1) begin errors++; $display("FAIL r0_fwd: got %b/%b want 0/1", fwd_valid, es2ms_valid); end
  endtask

  task automatic test_flush();
    int hits;
    @(negedge clk);
    drive(32'h1c00_0600, 32'd100, 32'd3, 32'd0, 12'd0, 3'd4, 1'b0, 1'b0, 1'b1, 2'd2, 5'd4);
    @(posedge clk);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    drive(32'h1c00_0604, 32'd10, 32'd20, 32'd0, ALU_ADD, 3'd0, 1'b0, 1'b0, 1'b1, 2'd2, 5'd7);
    #1;
    checks++; if (es2ms_valid !== 1'b0 || es_allowin !== 1'b1) begin errors++; $display("FAIL flush_div: got %b/%b want 0/1", es2ms_valid, es_allowin); end
    @(negedge clk);
    flush = 1'b0;
    ds2es_valid = 1'b0;
    #1;
    checks++; if (es2ms_valid !== 1'b1 || es_result !== 32'd30 || es_dest !== 5'd7) begin errors++; $display("FAIL flush_add: got %b/%h/%0d want 1/0000001e/7", es2ms_valid, es_result, es_dest); end
    hits = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (es2ms_valid) hits++;
    end
    checks++; if (hits != 0) begin errors++; $display("FAIL flush_no_div: got %0d want 0", hits); end
    drive(32'h1c00_0608, 32'h4000, 32'd0, 32'd5, ALU_ADD, 3'd0, 1'b1, 1'b0, 1'b0, 2'd2, 5'd0);
    @(negedge clk);
    ds2es_valid = 1'b0;
    flush = 1'b1;
    #1;
    checks++; if (data_sram_en !== 1'b0 || data_sram_we !== 4'b0000) begin errors++; $display("FAIL flush_st_en: got %b/%b want 0/0000", data_sram_en, data_sram_we); end
    @(negedge clk);
    flush = 1'b0;
    #1;
    checks++; if (data_sram_en !== 1'b0 || es2ms_valid !== 1'b0) begin errors++; $display("FAIL flush_st_drop: got %b/%b want 0/0", data_sram_en, es2ms_valid); end
  endtask

  task automatic test_async_reset();
    logic [31:0] r; int c, l, s; bit t;
    @(negedge clk);
    drive(32'h1c00_0700, 32'd99, 32'd4, 32'd0, 12'd0, 3'd5, 1'b0, 1'b0, 1'b1, 2'd2, 5'd3);
    @(posedge clk);
    @(negedge clk);
    ds2es_valid = 1'b0;
    repeat (5) @(negedge clk);
    #3;
    resetn = 1'b0;
    #1;
    checks++; if (fwd_valid !== 1'b0 || es2ms_valid !== 1'b0) begin errors++; $display("FAIL arst_valid: got %b/%b want 0/0", fwd_valid, es2ms_valid); end
    checks++; if (data_sram_en !== 1'b0 || es_result !== 32'd0) begin errors++; $display("FAIL arst_outputs: got %b/%h want 0/0", data_sram_en, es_result); end
    @(negedge clk);
    resetn = 1'b1;
    #1;
    checks++; if (es_allowin !== 1'b1) begin errors++; $display("FAIL arst_allowin: got %b want 1", es_allowin); end
    run_op(ALU_ADD, 3'd0, 32'd40, 32'd2, r, c, l, s, t);
    checks++; if (t || c != 1 || r !== 32'd42) begin errors++; $display("FAIL arst_idle: got %h in %0d want 0000002a in 1", r, c); end
  endtask

  initial begin
    resetn = 1'b0; ds2es_valid = 1'b0; flush = 1'b0; ms_allowin = 1'b1;
    ds_pc = '0; ds_src1 = '0; ds_src2 = '0; ds_rkd = '0; ds_alu_op = '0; ds_md_op = '0;
    ds_mem_we = 1'b0; ds_res_from_mem = 1'b0; ds_gr_we = 1'b0; ds_mem_size = 2'd2; ds_dest = '0;
    test_reset();
    test_add();
    test_mul();
    test_div();
    test_back_to_back();
    test_store();
    test_forward();
    test_flush();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
